// File: rtl/taxi_axis_pattern_src.sv
// AXI4-Stream pattern source: emits framed traffic of programmable length, count,
// inter-frame gap and data pattern. It honours backpressure and idles when mode is off.
module taxi_axis_pattern_src #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic [KEEP_W-1:0] m_axis_tkeep_o,
  output logic [KEEP_W-1:0] m_axis_tstrb_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tlast_o,
  output logic [ID_W-1:0]   m_axis_tid_o,
  output logic [DEST_W-1:0] m_axis_tdest_o,
  output logic [USER_W-1:0] m_axis_tuser_o,
  input  logic              enable_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [LEN_W-1:0]  cfg_frame_len_i,
  input  logic [CNT_W-1:0]  cfg_frame_count_i,
  input  logic [GAP_W-1:0]  cfg_gap_i,
  input  logic [7:0]        cfg_fill_i,
  input  logic [ID_W-1:0]   cfg_id_i,
  input  logic [DEST_W-1:0] cfg_dest_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  run_frames_o,
  output logic [CNT_W-1:0]  total_frames_o,
  output logic [CNT_W-1:0]  total_bytes_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int OFF_W = LEN_W + 8;

  logic [1:0]        state_q, state_d;
  logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W:0]    len_q;
  logic [1:0]        mode_q;
  logic [7:0]        fill_q, seq_q;
  logic [DATA_W-1:0] tdata_q;
  logic [KEEP_W-1:0] tkeep_q;
  logic              tvalid_q, tlast_q, busy_q;
  logic [ID_W-1:0]   tid_q;
  logic [DEST_W-1:0] tdest_q;
  logic [CNT_W-1:0]  runFrames_q, totalFrames_q, totalBytes_q, totalFrames_d;

  logic              handshake, lastHs, canStart, countHit;
  logic              start, advance, stopValid, runClear;
  logic [LEN_W:0]    effLenIn, genLen;
  logic [LEN_W-1:0]  genBeat;
  logic [1:0]        genMode;
  logic [7:0]        genFill, genSeq;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] beatData;
  logic [KEEP_W-1:0] beatKeep;
  logic              beatLast;
  logic [CNT_W-1:0]  keepCount;

  always_comb begin
    effLenIn      = (cfg_frame_len_i == '0) ? (LEN_W+1)'(1) : {1'b0, cfg_frame_len_i};
    handshake     = tvalid_q & m_axis_tready_i;
    lastHs        = handshake & tlast_q;
    canStart      = enable_i && (cfg_mode_i != 2'd0);
    countHit      = (cfg_frame_count_i != '0) && (runFrames_q + CNT_W'(1) == cfg_frame_count_i);
    totalFrames_d = lastHs ? totalFrames_q + CNT_W'(1) : totalFrames_q;
  end

  always_comb begin
    state_d   = state_q;
    gapCnt_d  = gapCnt_q;
    start     = 1'b0;
    advance   = 1'b0;
    stopValid = 1'b0;
    runClear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (canStart) start = 1'b1;
        else if (!enable_i) runClear = 1'b1;
      end
      ST_FRAME: begin
        if (lastHs) begin
          if (countHit) begin
            state_d   = ST_DONE;
            stopValid = 1'b1;
          end else if (cfg_gap_i != '0) begin
            state_d   = ST_GAP;
            gapCnt_d  = cfg_gap_i;
            stopValid = 1'b1;
          end else if (canStart) begin
            start = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            stopValid = 1'b1;
          end
        end else if (handshake) begin
          advance = 1'b1;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GAP_W'(1)) begin
          if (canStart) start = 1'b1;
          else state_d = ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q - GAP_W'(1);
        end
      end
      default: begin
        if (!enable_i) begin
          state_d  = ST_IDLE;
          runClear = 1'b1;
        end
      end
    endcase
    if (start) state_d = ST_FRAME;
  end

  // A new frame's first beat is built from live config; later beats from the latched copy.
  always_comb begin
    genMode  = start ? cfg_mode_i : mode_q;
    genFill  = start ? cfg_fill_i : fill_q;
    genSeq   = start ? totalFrames_d[7:0] : seq_q;
    genLen   = start ? effLenIn : len_q;
    genBeat  = start ? '0 : beat_q + LEN_W'(1);
    beatData = '0;
    beatKeep = '0;
    off      = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      off = OFF_W'(genBeat) * OFF_W'(KEEP_W) + OFF_W'(k);
      if (off < OFF_W'(genLen)) begin
        beatKeep[k] = 1'b1;
        case (genMode)
          2'd1:    beatData[k*8 +: 8] = off[7:0];
          2'd2:    beatData[k*8 +: 8] = genFill;
          2'd3:    beatData[k*8 +: 8] = genSeq;
          default: beatData[k*8 +: 8] = 8'd0;
        endcase
      end
    end
    beatLast = (OFF_W'(genBeat) + OFF_W'(1)) * OFF_W'(KEEP_W) >= OFF_W'(genLen);
  end

  always_comb begin
    keepCount = '0;
    for (int k = 0; k < KEEP_W; k++) keepCount = keepCount + CNT_W'(tkeep_q[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gapCnt_q      <= '0;
      beat_q        <= '0;
      len_q         <= '0;
      mode_q        <= 2'd0;
      fill_q        <= 8'd0;
      seq_q         <= 8'd0;
      tdata_q       <= '0;
      tkeep_q       <= '1;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tid_q         <= '0;
      tdest_q       <= '0;
      busy_q        <= 1'b0;
      runFrames_q   <= '0;
      totalFrames_q <= '0;
      totalBytes_q  <= '0;
    end else begin
      state_q       <= state_d;
      gapCnt_q      <= gapCnt_d;
      busy_q        <= (state_d != ST_IDLE);
      totalFrames_q <= totalFrames_d;
      if (start) begin
        beat_q  <= '0;
        len_q   <= effLenIn;
        mode_q  <= cfg_mode_i;
        fill_q  <= cfg_fill_i;
        seq_q   <= totalFrames_d[7:0];
        tid_q   <= cfg_id_i;
        tdest_q <= cfg_dest_i;
      end else if (advance) begin
        beat_q <= beat_q + LEN_W'(1);
      end
      if (start || advance) begin
        tvalid_q <= 1'b1;
        tdata_q  <= beatData;
        tkeep_q  <= beatKeep;
        tlast_q  <= beatLast;
      end else if (stopValid) begin
        tvalid_q <= 1'b0;
      end
      if (handshake) totalBytes_q <= totalBytes_q + keepCount;
      if (runClear) runFrames_q <= '0;
      else if (lastHs) runFrames_q <= runFrames_q + CNT_W'(1);
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tkeep_o  = tkeep_q;
  assign m_axis_tstrb_o  = tkeep_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tid_o    = tid_q;
  assign m_axis_tdest_o  = tdest_q;
  assign m_axis_tuser_o  = '0;
  assign busy_o          = busy_q;
  assign run_frames_o    = runFrames_q;
  assign total_frames_o  = totalFrames_q;
  assign total_bytes_o   = totalBytes_q;

endmodule

// File: tb/tb_taxi_axis_pattern_src.sv
// Directed self-checking bench for taxi_axis_pattern_src with a 64-bit stream.
module tb_taxi_axis_pattern_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata;
  logic [7:0]  tkeep, tstrb;
  logic        tvalid, tlast;
  logic        tready = 1'b1;
  logic [7:0]  tid, tdest;
  logic [0:0]  tuser;
  logic        enable = 1'b0;
  logic [1:0]  cfgMode = 2'd0;
  logic [15:0] cfgLen = 16'd0;
  logic [31:0] cfgCount = 32'd0;
  logic [7:0]  cfgGap = 8'd0;
  logic [7:0]  cfgFill = 8'd0;
  logic [7:0]  cfgId = 8'd0;
  logic [7:0]  cfgDest = 8'd0;
  logic        busy;
  logic [31:0] runFrames, totalFrames, totalBytes;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  taxi_axis_pattern_src dut (
    .clk               (clk),
    .rst               (rst),
    .m_axis_tdata_o    (tdata),
    .m_axis_tkeep_o    (tkeep),
    .m_axis_tstrb_o    (tstrb),
    .m_axis_tvalid_o   (tvalid),
    .m_axis_tready_i   (tready),
    .m_axis_tlast_o    (tlast),
    .m_axis_tid_o      (tid),
    .m_axis_tdest_o    (tdest),
    .m_axis_tuser_o    (tuser),
    .enable_i          (enable),
    .cfg_mode_i        (cfgMode),
    .cfg_frame_len_i   (cfgLen),
    .cfg_frame_count_i (cfgCount),
    .cfg_gap_i         (cfgGap),
    .cfg_fill_i        (cfgFill),
    .cfg_id_i          (cfgId),
    .cfg_dest_i        (cfgDest),
    .busy_o            (busy),
    .run_frames_o      (runFrames),
    .total_frames_o    (totalFrames),
    .total_bytes_o     (totalBytes)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] len, input logic [31:0] count,
                               input logic [7:0] gap, input logic [7:0] fill);
    cfgMode  = mode;
    cfgLen   = len;
    cfgCount = count;
    cfgGap   = gap;
    cfgFill  = fill;
  endtask

  function automatic logic [63:0] incWord(input int b, input int nBytes);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (k < nBytes) w[k*8 +: 8] = 8'(b * 8 + k);
    return w;
  endfunction

  task automatic expectBeat(input string tag, input logic [63:0] d, input logic [7:0] keep, input logic last);
    checkOutput({tag, ".valid"}, 64'(tvalid), 64'd1);
    checkOutput({tag, ".data"}, tdata, d);
    checkOutput({tag, ".keep"}, 64'(tkeep), 64'(keep));
    checkOutput({tag, ".last"}, 64'(tlast), 64'(last));
    stepCycle();
  endtask

  initial begin
    logic [63:0] expData;
    logic [7:0]  expKeep;
    logic        expLast;
    int          beatIdx;
    bit          done;

    // reset state
    stepCycle();
    stepCycle();
    checkOutput("rstValid", 64'(tvalid), 64'd0);
    checkOutput("rstLast", 64'(tlast), 64'd0);
    checkOutput("rstData", tdata, 64'd0);
    checkOutput("rstKeep", 64'(tkeep), 64'hFF);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstBytes", 64'(totalBytes), 64'd0);
    checkOutput("rstFrames", 64'(totalFrames), 64'd0);
    rst = 1'b0;
    stepCycle();

    // two back-to-back 20-byte incrementing frames, then DONE
    $display("[TB] back-to-back incrementing frames");
    applyStimulus(2'd1, 16'd20, 32'd2, 8'd0, 8'd0);
    cfgId   = 8'h5A;
    cfgDest = 8'h03;
    enable  = 1'b1;
    stepCycle();
    checkOutput("tid", 64'(tid), 64'h5A);
    checkOutput("tdest", 64'(tdest), 64'h03);
    checkOutput("tstrb", 64'(tstrb), 64'hFF);
    checkOutput("tuser", 64'(tuser), 64'd0);
    for (int f = 0; f < 2; f++) begin
      expectBeat("f1b0", incWord(0, 8), 8'hFF, 1'b0);
      expectBeat("f1b1", incWord(1, 8), 8'hFF, 1'b0);
      expectBeat("f1b2", incWord(2, 4), 8'h0F, 1'b1);
    end
    checkOutput("doneValid", 64'(tvalid), 64'd0);
    checkOutput("doneBusy", 64'(busy), 64'd1);
    checkOutput("doneRun", 64'(runFrames), 64'd2);
    checkOutput("doneBytes", 64'(totalBytes), 64'd40);
    checkOutput("doneFrames", 64'(totalFrames), 64'd2);
    enable = 1'b0;
    stepCycle();
    checkOutput("idleBusy", 64'(busy), 64'd0);
    checkOutput("idleRun", 64'(runFrames), 64'd0);

    // random backpressure with fill pattern
    $display("[TB] backpressure fill");
    applyStimulus(2'd2, 16'd20, 32'd1, 8'd0, 8'hA5);
    enable  = 1'b1;
    beatIdx = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      stepCycle();
      tready  = 1'($urandom_range(0, 1));
      expData = (beatIdx < 2) ? 64'hA5A5A5A5A5A5A5A5 : 64'h00000000A5A5A5A5;
      expKeep = (beatIdx < 2) ? 8'hFF : 8'h0F;
      expLast = (beatIdx >= 2);
      checkOutput("bpValid", 64'(tvalid), 64'd1);
      checkOutput("bpData", tdata, expData);
      checkOutput("bpKeep", 64'(tkeep), 64'(expKeep));
      checkOutput("bpLast", 64'(tlast), 64'(expLast));
      if (tready && tvalid) begin
        beatIdx++;
        if (tlast) done = 1'b1;
      end
    end
    checkOutput("bpFinished", 64'(done), 64'd1);
    checkOutput("bpBeats", 64'(beatIdx), 64'd3);
    stepCycle();
    tready = 1'b1;
    checkOutput("bpDoneValid", 64'(tvalid), 64'd0);
    checkOutput("bpBytes", 64'(totalBytes), 64'd60);
    enable = 1'b0;
    stepCycle();

    // gap of 3 with sequence-number frames
    $display("[TB] gap and sequence pattern");
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    applyStimulus(2'd3, 16'd8, 32'd0, 8'd3, 8'd0);
    enable = 1'b1;
    stepCycle();
    for (int f = 0; f < 3; f++) begin
      expData = {8{8'(f)}};
      expectBeat("seqBeat", expData, 8'hFF, 1'b1);
      if (f == 2) enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checkOutput("gapIdle", 64'(tvalid), 64'd0);
        stepCycle();
      end
    end
    checkOutput("gapEndValid", 64'(tvalid), 64'd0);
    checkOutput("gapEndBusy", 64'(busy), 64'd0);
    checkOutput("gapFrames", 64'(totalFrames), 64'd3);

    // enable dropped mid-frame: frame still completes
    $display("[TB] enable dropped mid-frame");
    applyStimulus(2'd1, 16'd40, 32'd0, 8'd0, 8'd0);
    enable = 1'b1;
    stepCycle();
    expectBeat("dropB0", incWord(0, 8), 8'hFF, 1'b0);
    enable = 1'b0;
    for (int b = 1; b < 5; b++) expectBeat("dropBeat", incWord(b, 8), 8'hFF, (b == 4));
    checkOutput("dropValid", 64'(tvalid), 64'd0);
    checkOutput("dropBusy", 64'(busy), 64'd0);
    checkOutput("dropFrames", 64'(totalFrames), 64'd4);

    // asynchronous reset mid-frame
    $display("[TB] reset mid-frame");
    enable = 1'b1;
    stepCycle();
    expectBeat("preRst0", incWord(0, 8), 8'hFF, 1'b0);
    expectBeat("preRst1", incWord(1, 8), 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("arstValid", 64'(tvalid), 64'd0);
    checkOutput("arstBytes", 64'(totalBytes), 64'd0);
    checkOutput("arstFrames", 64'(totalFrames), 64'd0);
    checkOutput("arstBusy", 64'(busy), 64'd0);
    stepCycle();
    rst = 1'b0;
    stepCycle();
    expectBeat("postRst0", incWord(0, 8), 8'hFF, 1'b0);
    enable = 1'b0;
    for (int b = 1; b < 5; b++) expectBeat("postRst", incWord(b, 8), 8'hFF, (b == 4));

    // mode off keeps the source silent
    $display("[TB] mode off");
    applyStimulus(2'd0, 16'd20, 32'd0, 8'd0, 8'd0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("offValid", 64'(tvalid), 64'd0);
      checkOutput("offBusy", 64'(busy), 64'd0);
    end
    enable = 1'b0;
    stepCycle();

    // zero length is sent as one byte
    $display("[TB] length edge cases");
    applyStimulus(2'd2, 16'd0, 32'd1, 8'd0, 8'h3C);
    enable = 1'b1;
    stepCycle();
    expectBeat("len0", 64'h3C, 8'h01, 1'b1);
    checkOutput("len0Done", 64'(busy), 64'd1);
    checkOutput("len0Run", 64'(runFrames), 64'd1);
    enable = 1'b0;
    stepCycle();
    stepCycle();
    applyStimulus(2'd1, 16'd8, 32'd1, 8'd0, 8'd0);
    enable = 1'b1;
    stepCycle();
    expectBeat("len8", incWord(0, 8), 8'hFF, 1'b1);
    checkOutput("len8Valid", 64'(tvalid), 64'd0);
    enable = 1'b0;
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
